// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: MIPS multicycle control FSM with parameterised
// memory wait states and an Enter-paced IN instruction.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT   = 0,
  parameter bit          ENTER_EDGE = 1'b1
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       enter,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       out_write,
  output logic       halted,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_IN_WAIT   = 4'd11,
    S_OUT       = 4'd12,
    S_HALT      = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_IN   = 6'b111100;
  localparam logic [5:0] OP_OUT  = 6'b111101;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [3:0] W_LAST  = 4'(MEM_WAIT);

  state_t     st, st_nx;
  logic [3:0] cnt, cnt_nx;
  logic [5:0] op_q;
  logic       run_q, ill_q, enter_q, jr_q;
  logic       set_ill, last, rel, is_jr;

  assign last    = (cnt == W_LAST);
  assign rel     = ENTER_EDGE ? (enter & ~enter_q) : enter;
  assign is_jr   = (opcode == OP_R) && (funct == FN_JR);
  assign illegal = ill_q;
  assign state   = st;

  // run_q holds outputs quiet until the first edge after reset
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      st      <= S_FETCH;
      cnt     <= '0;
      run_q   <= 1'b0;
      ill_q   <= 1'b0;
      enter_q <= 1'b0;
      op_q    <= '0;
      jr_q    <= 1'b0;
    end else begin
      st      <= st_nx;
      cnt     <= cnt_nx;
      run_q   <= 1'b1;
      enter_q <= enter;
      if (set_ill) ill_q <= 1'b1;
      if (st == S_DECODE) begin
        op_q <= opcode;
        jr_q <= is_jr;
      end
    end
  end

  always_comb begin
    st_nx      = st;
    cnt_nx     = '0;
    set_ill    = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    pc_source  = 2'b00;
    out_write  = 1'b0;
    halted     = 1'b0;
    if (run_q) begin
      unique case (st)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (last) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            st_nx    = S_DECODE;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          unique case (1'b1)
            (opcode == OP_LW) || (opcode == OP_SW):
              st_nx = S_MEM_ADDR;
            is_jr:
              st_nx = S_JUMP;
            (opcode == OP_R) && !is_jr:
              st_nx = S_EXEC;
            (opcode == OP_BEQ) || (opcode == OP_BNE):
              st_nx = S_BRANCH;
            (opcode == OP_ADDI):
              st_nx = S_ADDI_EX;
            (opcode == OP_J) || (opcode == OP_JAL):
              st_nx = S_JUMP;
            (opcode == OP_IN):
              st_nx = S_IN_WAIT;
            (opcode == OP_OUT):
              st_nx = S_OUT;
            (opcode == OP_HALT):
              st_nx = S_HALT;
            default: begin
              set_ill = 1'b1;
              st_nx   = S_FETCH;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          st_nx = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (last) st_nx = S_MEM_WB;
          else cnt_nx = cnt + 4'd1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
          st_nx      = S_FETCH;
        end
        S_MEM_WRITE: begin
          iord = 1'b1;
          if (last) begin
            mem_write = 1'b1;
            st_nx     = S_FETCH;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b010;
          st_nx     = S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = (op_q == OP_ADDI) ? 2'b00 : 2'b01;
          st_nx     = S_FETCH;
        end
        S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          st_nx     = S_ALU_WB;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b001;
          pc_source = 2'b01;
          pc_write  = ((op_q == OP_BEQ) & zero)
                    | ((op_q == OP_BNE) & ~zero);
          st_nx     = S_FETCH;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = jr_q ? 2'b11 : 2'b10;
          if (op_q == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
          st_nx = S_FETCH;
        end
        S_IN_WAIT: begin
          if (rel) begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b11;
            st_nx      = S_FETCH;
          end
        end
        S_OUT: begin
          out_write = 1'b1;
          st_nx     = S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: st_nx = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench with an instruction-level
// model of the control sequence for three parameter sets.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  localparam int P_FETCH = 0,  P_DECODE = 1,  P_MEM_ADDR = 2;
  localparam int P_MEM_READ = 3, P_MEM_WB = 4, P_MEM_WRITE = 5;
  localparam int P_EXEC = 6,   P_ALU_WB = 7,  P_BRANCH = 8;
  localparam int P_JUMP = 9,   P_ADDI_EX = 10, P_IN_WAIT = 11;
  localparam int P_OUT = 12,   P_HALT = 13,   P_OFF = 15;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_IN   = 6'b111100;
  localparam logic [5:0] OP_OUT  = 6'b111101;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_BAD  = 6'b111110;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam int NW [3] = '{0, 2, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rstn;
  logic [5:0]  opcode, funct;
  logic        zero, enter;
  logic [24:0] obs [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GW = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    localparam bit GE = (g == 2) ? 1'b0 : 1'b1;
    logic       pcw, irw, io, mr, mw, rw, aa, ow, hl, il;
    logic [1:0] rd, m2r, ab, ps;
    logic [2:0] ao;
    logic [3:0] st;
    multicycle_ctrl #(.MEM_WAIT(GW), .ENTER_EDGE(GE)) u_dut (
      .CLK(clk), .reset(rstn[g]), .opcode(opcode), .funct(funct),
      .zero(zero), .enter(enter), .pc_write(pcw), .ir_write(irw),
      .iord(io), .mem_read(mr), .mem_write(mw), .reg_write(rw),
      .reg_dst(rd), .mem_to_reg(m2r), .alu_src_a(aa),
      .alu_src_b(ab), .alu_op(ao), .pc_source(ps),
      .out_write(ow), .halted(hl), .illegal(il), .state(st)
    );
    assign obs[g] = {pcw, irw, io, mr, mw, rw, rd, m2r, aa,
                     ab, ao, ps, ow, hl, il, st};
  end

  int          cur, n_chk, n_pass, n_cyc, n_ir, n_pc, n_fst;
  logic [5:0]  m_op;
  bit          m_zero, m_jr, m_ill, chk_en;
  logic [24:0] exp_v, l_obs;
  string       tag;

  // Expected outputs of one cycle from the per-state output table.
  function automatic logic [24:0] vec(input int ph, input bit last,
                                      input bit rel);
    logic       pcw, irw, io, mr, mw, rw, aa, ow, hl;
    logic [1:0] rd, m2r, ab, ps;
    logic [2:0] ao;
    {pcw, irw, io, mr, mw, rw, aa, ow, hl} = '0;
    rd = '0; m2r = '0; ab = '0; ps = '0; ao = '0;
    if (ph == P_OFF) return '0;
    case (ph)
      P_FETCH:     begin mr = 1; ab = 2'b01; irw = last; pcw = last; end
      P_DECODE:    ab = 2'b11;
      P_MEM_ADDR:  begin aa = 1; ab = 2'b10; end
      P_MEM_READ:  begin mr = 1; io = 1; end
      P_MEM_WB:    begin rw = 1; m2r = 2'b01; end
      P_MEM_WRITE: begin io = 1; mw = last; end
      P_EXEC:      begin aa = 1; ao = 3'b010; end
      P_ALU_WB:    begin rw = 1; rd = (m_op == OP_ADDI) ? 2'b00 : 2'b01; end
      P_ADDI_EX:   begin aa = 1; ab = 2'b10; end
      P_BRANCH: begin
        aa = 1; ao = 3'b001; ps = 2'b01;
        pcw = (m_op == OP_BEQ) ? m_zero : !m_zero;
      end
      P_JUMP: begin
        pcw = 1; ps = m_jr ? 2'b11 : 2'b10;
        if (m_op == OP_JAL) begin rw = 1; rd = 2'b10; m2r = 2'b10; end
      end
      P_IN_WAIT:   if (rel) begin rw = 1; m2r = 2'b11; end
      P_OUT:       ow = 1;
      P_HALT:      hl = 1;
      default:     ;
    endcase
    return {pcw, irw, io, mr, mw, rw, rd, m2r, aa, ab, ao, ps,
            ow, hl, m_ill, 4'(ph)};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (obs[cur] === exp_v) n_pass++;
      else $display("FAIL cyc[%s] dut%0d got=%h want=%h",
                    tag, cur, obs[cur], exp_v);
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", name, got, want);
  endtask

  task automatic cyc(input int ph, input bit last, input bit rel);
    exp_v  = vec(ph, last, rel);
    chk_en = 1'b1;
    @(negedge clk);
    l_obs = obs[cur];
    if (ph == P_FETCH) begin
      n_ir += int'(l_obs[23]);
      n_pc += int'(l_obs[24]);
      if (l_obs[3:0] == 4'd0) n_fst++;
    end
    n_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [5:0] op, input logic [5:0] fn,
                       input bit z);
    n_cyc = 0; n_ir = 0; n_pc = 0; n_fst = 0;
    opcode = op; funct = fn; zero = z;
    m_op = op; m_zero = z;
    m_jr = (op == OP_R) && (fn == FN_JR);
    for (int i = 0; i <= NW[cur]; i++) cyc(P_FETCH, i == NW[cur], 0);
    cyc(P_DECODE, 0, 0);
  endtask

  task automatic instr(input string t, input logic [5:0] op,
                       input logic [5:0] fn, input bit z,
                       output int n);
    int w;
    w = NW[cur];
    tag = t;
    start(op, fn, z);
    case (op)
      OP_R: begin
        if (m_jr) cyc(P_JUMP, 0, 0);
        else begin cyc(P_EXEC, 0, 0); cyc(P_ALU_WB, 0, 0); end
      end
      OP_LW: begin
        cyc(P_MEM_ADDR, 0, 0);
        for (int i = 0; i <= w; i++) cyc(P_MEM_READ, 0, 0);
        cyc(P_MEM_WB, 0, 0);
      end
      OP_SW: begin
        cyc(P_MEM_ADDR, 0, 0);
        for (int i = 0; i <= w; i++) cyc(P_MEM_WRITE, i == w, 0);
      end
      OP_BEQ, OP_BNE: cyc(P_BRANCH, 0, 0);
      OP_ADDI: begin cyc(P_ADDI_EX, 0, 0); cyc(P_ALU_WB, 0, 0); end
      OP_J, OP_JAL: cyc(P_JUMP, 0, 0);
      OP_OUT: cyc(P_OUT, 0, 0);
      OP_HALT: begin
        for (int i = 0; i < 100; i++) begin
          enter = (i % 2) == 1;
          cyc(P_HALT, 0, 0);
        end
        enter = 1'b0;
      end
      default: m_ill = 1'b1;
    endcase
    n = n_cyc;
  endtask

  task automatic do_in(input string t, input int hi, input int lo,
                       output int n);
    tag = t;
    enter = (hi > 0);
    start(OP_IN, 6'd0, 1'b0);
    for (int i = 0; i < hi; i++) cyc(P_IN_WAIT, 0, 0);
    enter = 1'b0;
    for (int i = 0; i < lo; i++) cyc(P_IN_WAIT, 0, 0);
    enter = 1'b1;
    cyc(P_IN_WAIT, 0, 1);
    enter = 1'b0;
    n = n_cyc;
  endtask

  initial begin
    int n;
    rstn = '0; opcode = '0; funct = '0; zero = 0; enter = 0;
    chk_en = 0; cur = 0; m_ill = 0; n_chk = 0; n_pass = 0;
    m_op = '0; m_zero = 0; m_jr = 0; tag = "reset";
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("reset_dut%0d", k), 32'(obs[k]), 32'd0);

    // W=0, edge-released IN
    cur = 0; rstn[0] = 1'b1; tag = "idle0";
    cyc(P_OFF, 0, 0);
    instr("r", OP_R, FN_ADD, 0, n);     check("cpi_r", n, 4);
    check("fetch_ir_once", n_ir, 1);
    check("fetch_pc_once", n_pc, 1);
    instr("lw", OP_LW, 0, 0, n);        check("cpi_lw", n, 5);
    instr("sw", OP_SW, 0, 0, n);        check("cpi_sw", n, 4);
    instr("beq", OP_BEQ, 0, 1, n);      check("cpi_beq", n, 3);
    check("beq_taken", 32'(l_obs[24]), 1);
    instr("bne", OP_BNE, 0, 1, n);      check("cpi_bne", n, 3);
    check("bne_not_taken", 32'(l_obs[24]), 0);
    instr("addi", OP_ADDI, 0, 0, n);    check("cpi_addi", n, 4);
    instr("j", OP_J, 0, 0, n);          check("cpi_j", n, 3);
    instr("jr", OP_R, FN_JR, 0, n);     check("cpi_jr", n, 3);
    check("jr_pc_source", 32'(l_obs[8:7]), 3);
    instr("out", OP_OUT, 0, 0, n);      check("cpi_out", n, 3);
    check("out_strobe", 32'(l_obs[6]), 1);
    instr("bad", OP_BAD, 0, 0, n);      check("cpi_bad", n, 2);
    instr("r2", OP_R, FN_ADD, 0, n);
    check("illegal_sticky", 32'(obs[0][4]), 1);
    do_in("in_edge", 3, 2, n);          check("cpi_in_edge", n, 8);
    check("in_wb_sel", 32'(l_obs[16:15]), 3);
    instr("halt", OP_HALT, 0, 0, n);    check("cpi_halt_hold", n, 102);
    check("halt_state", 32'(l_obs[3:0]), 13);
    check("halt_flag", 32'(l_obs[5]), 1);
    rstn[0] = 1'b0; m_ill = 0; tag = "halt_rst";
    cyc(P_OFF, 0, 0);
    check("halt_cleared", 32'(l_obs[5]), 0);
    check("illegal_cleared", 32'(l_obs[4]), 0);

    // W=2
    cur = 1; rstn[1] = 1'b1; tag = "idle1";
    cyc(P_OFF, 0, 0);
    instr("jal", OP_JAL, 0, 0, n);      check("cpi_jal_w2", n, 5);
    check("jal_state", 32'(l_obs[3:0]), 9);
    check("jal_reg_write", 32'(l_obs[19]), 1);
    check("jal_reg_dst", 32'(l_obs[18:17]), 2);
    check("jal_mem_to_reg", 32'(l_obs[16:15]), 2);
    check("jal_pc_source", 32'(l_obs[8:7]), 2);
    instr("lw2", OP_LW, 0, 0, n);       check("cpi_lw_w2", n, 9);
    instr("sw2", OP_SW, 0, 0, n);       check("cpi_sw_w2", n, 8);

    // W=3, level-released IN, reset in the middle of MEM_READ
    cur = 2; rstn[2] = 1'b1; tag = "idle2";
    cyc(P_OFF, 0, 0);
    tag = "lw_cut";
    start(OP_LW, 0, 0);
    cyc(P_MEM_ADDR, 0, 0);
    cyc(P_MEM_READ, 0, 0);
    cyc(P_MEM_READ, 0, 0);
    rstn[2] = 1'b0; m_ill = 0; tag = "mid_rst";
    cyc(P_OFF, 0, 0);
    check("rst_mid_state", 32'(l_obs[3:0]), 0);
    rstn[2] = 1'b1;
    cyc(P_OFF, 0, 0);
    instr("r3", OP_R, FN_ADD, 0, n);    check("cpi_r_w3", n, 7);
    check("fetch_len_w3", n_fst, 4);
    check("fetch_ir_w3", n_ir, 1);
    check("fetch_pc_w3", n_pc, 1);
    do_in("in_lvl", 0, 2, n);           check("cpi_in_lvl", n, 8);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
